// File: rtl/usb_token_tx_pkg.sv
// Shared USB constants: PID codes, CRC5 parameters and the token transmitter FSM states.
package usb_token_tx_pkg;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_PING  = 4'h4;
    localparam logic [3:0] PID_SOF   = 4'h5;

    localparam logic [4:0] CRC5_INIT = 5'h1F;
    // x^5 + x^2 + 1 with the x^5 term implied by the shift-out
    localparam logic [4:0] CRC5_POLY = 5'h05;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PID,
        ST_B1,
        ST_B2
    } state_t;

    function automatic logic isTokenPid(input logic [3:0] pid);
        return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SETUP) || (pid == PID_PING);
    endfunction

endpackage

// File: rtl/usb_token_tx_crc5.sv
// Combinational USB CRC5 step over 11 data bits, consumed LSB first as they go on the wire.
module usb_token_tx_crc5
    import usb_token_tx_pkg::*;
(
    input  logic [4:0]  i_c,
    input  logic [10:0] i_d,
    output logic [4:0]  o_c
);

    logic [4:0] w_crc;

    always_comb begin
        w_crc = i_c;
        for (int i = 0; i < 11; i++) begin
            w_crc = {w_crc[3:0], 1'b0} ^ (((i_d[i] ^ w_crc[4]) == 1'b1) ? CRC5_POLY : 5'h00);
        end
    end

    assign o_c = w_crc;

endmodule

// File: rtl/usb_token_tx.sv
// USB token/SOF packet transmitter: arbitrates two requesters, then emits PID, data and CRC5 bytes.
module usb_token_tx
    import usb_token_tx_pkg::*;
#(
    parameter bit SOF_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tok_req,
    input  logic [3:0]  tok_pid,
    input  logic [6:0]  tok_addr,
    input  logic [3:0]  tok_endp,
    output logic        tok_ack,
    output logic        tok_err,
    input  logic        sof_req,
    input  logic [10:0] sof_frame,
    output logic        sof_ack,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        pkt_done
);

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_pid;
    logic [10:0] r_d11;
    logic        r_pktDone;
    logic        w_sofGrant;
    logic        w_tokGrant;
    logic        w_tokLegal;
    logic [4:0]  w_crcRaw;
    logic [4:0]  w_crcTx;

    assign w_tokLegal = isTokenPid(tok_pid);

    usb_token_tx_crc5 u_crc5 (
        .i_c (CRC5_INIT),
        .i_d (r_d11),
        .o_c (w_crcRaw)
    );

    // USB sends the CRC inverted and MSB first, while bytes go out LSB first
    assign w_crcTx = ~{w_crcRaw[0], w_crcRaw[1], w_crcRaw[2], w_crcRaw[3], w_crcRaw[4]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_sofGrant  = 1'b0;
        w_tokGrant  = 1'b0;
        sof_ack     = 1'b0;
        tok_ack     = 1'b0;
        tok_err     = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (sof_req && (SOF_FIRST || !tok_req)) begin
                    w_sofGrant = 1'b1;
                end else if (tok_req) begin
                    w_tokGrant = 1'b1;
                end
                sof_ack = w_sofGrant;
                tok_ack = w_tokGrant;
                // An illegal token is acknowledged and flagged but never transmitted
                tok_err = w_tokGrant && !w_tokLegal;
                if (w_sofGrant || (w_tokGrant && w_tokLegal)) begin
                    w_nextState = ST_PID;
                end
            end
            ST_PID: begin
                tx_valid = 1'b1;
                tx_data  = {~r_pid, r_pid};
                if (tx_ready) begin
                    w_nextState = ST_B1;
                end
            end
            ST_B1: begin
                tx_valid = 1'b1;
                tx_data  = r_d11[7:0];
                if (tx_ready) begin
                    w_nextState = ST_B2;
                end
            end
            ST_B2: begin
                tx_valid = 1'b1;
                tx_data  = {w_crcTx, r_d11[10:8]};
                if (tx_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pid <= 4'h0;
            r_d11 <= 11'h000;
        end else if (w_sofGrant) begin
            r_pid <= PID_SOF;
            r_d11 <= sof_frame;
        end else if (w_tokGrant && w_tokLegal) begin
            r_pid <= tok_pid;
            r_d11 <= {tok_endp, tok_addr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pktDone <= 1'b0;
        end else begin
            r_pktDone <= (r_state == ST_B2) && tx_ready;
        end
    end

    assign pkt_done = r_pktDone;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: doc/usb_token_tx.md
USB_TOKEN_TX -- requirements
Module: usb_token_tx

Interface
REQ-001 SHALL have parameter SOF_FIRST, default 1, meaning that when both requests are pending, SOF wins (0 = token wins).
REQ-002 SHALL have one clock and an asynchronous active-low reset, with ports:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous, active-low reset
REQ-003 SHALL have token request ports:
  tok_req  in  1  token request (level)
  tok_pid  in  4  PID nibble
  tok_addr  in  7  device address
  tok_endp  in  4  endpoint
  tok_ack  out  1  token accepted
  tok_err  out  1  PID illegal, dropped
REQ-004 SHALL have SOF request ports:
  sof_req  in  1  SOF request (level)
  sof_frame  in  11  frame number
  sof_ack  out  1  SOF accepted
REQ-005 SHALL have transmit and status ports:
  tx_data  out  8  byte to PHY
  tx_valid  out  1  byte valid
  tx_ready  in  1  PHY accepts byte
  busy  out  1  packet in progress
  pkt_done  out  1  packet complete

Function
REQ-006 SHALL use FSM states IDLE, PID, B1 and B2; busy = (state != IDLE).
REQ-007 In IDLE, SHALL grant at most one request per cycle using SOF_FIRST priority.
REQ-008 On grant, SHALL assert the matching ack combinationally in that cycle, latch the fields, and enter PID.
REQ-009 On an SOF grant, SHALL latch pid = 4'h5 and d11 = sof_frame.
REQ-010 On a token grant, SHALL latch d11 = {tok_endp, tok_addr}.
REQ-011 SHALL treat only tok_pid in {4'h1 OUT, 4'h9 IN, 4'hD SETUP, 4'h4 PING} as a legal token PID.
REQ-012 For an illegal token PID, SHALL pulse tok_ack and tok_err for one cycle, stay in IDLE, and emit no bytes.
REQ-013 SHALL treat a request still high after its ack as a new request.
REQ-014 SHALL compute crc_raw = CRC5 step with c = 5'h1F and d = latched d11, combinationally from the latched register.
REQ-015 SHALL form the transmitted CRC as crc_tx = bitwise inverse of crc_raw, bit-reversed (crc_tx[4] = ~crc_raw[0] ... crc_tx[0] = ~crc_raw[4]).
REQ-016 SHALL drive tx_data per state:
  PID: {~pid, pid}
  B1: d11[7:0]
  B2: {crc_tx, d11[10:8]}
REQ-017 SHALL drive tx_valid = 1 in PID, B1 and B2, starting the cycle after grant.
REQ-018 SHALL advance PID -> B1 -> B2 -> IDLE only on tx_valid && tx_ready.
REQ-019 SHALL hold tx_data stable while tx_valid && !tx_ready, with no timeout.
REQ-020 SHALL pulse pkt_done registered, one cycle after the B2 handshake.
REQ-021 SHALL give a minimum packet of 3 cycles at tx_ready = 1; grant-to-grant is 4 cycles (one IDLE bubble).
REQ-022 SHALL ignore requests while busy; acks are 0 outside IDLE.

Reset
REQ-023 On rst_n low, SHALL immediately set state = IDLE and clear the latched pid, d11, tx_valid, pkt_done and busy; acks and tok_err SHALL read 0.
REQ-024 On reset mid-packet, SHALL abort the packet with no pkt_done; the first grant is possible on the first clock edge after rst_n rises.

Structure
REQ-025 A shared usb package SHALL hold PID constants (OUT/IN/SETUP/PING/SOF), the CRC5 init value 5'h1F, and the FSM state enum.
REQ-026 SHALL instantiate exactly one sub-module, the existing combinational crc5 step block (c[4:0], d[10:0] -> c_out[4:0]), shared by both requesters.
REQ-027 SHALL contain no other arithmetic; latched registers SHALL feed the CRC directly.

Verification
REQ-028 Bench SHALL cover: SETUP token, addr 0, endp 0, tx_ready = 1 -> tx_data 8'h2D, 8'h00, 8'h10 on consecutive cycles, pkt_done next cycle.
REQ-029 Bench SHALL cover: sof_req and tok_req in the same IDLE cycle, SOF_FIRST = 1 -> only sof_ack; SOF sent (PID byte 8'hA5); token granted 4 cycles after the SOF grant.
REQ-030 Bench SHALL cover: tx_ready low for 5 cycles during B1 -> tx_data and tx_valid unchanged, state held, then completes normally.
REQ-031 Bench SHALL cover: tok_pid = 4'h3 -> tok_ack and tok_err one-cycle pulses, tx_valid stays 0, busy stays 0.
REQ-032 Bench SHALL cover: rst_n asserted in B2 -> tx_valid 0 immediately, no pkt_done; the next SOF (frame 11'h000) is sent complete.
REQ-033 Bench SHALL cover: random 1000 tokens/SOFs with random tx_ready -> every B2 CRC equals reference-model CRC5 of d11, and every packet is exactly 3 bytes.
